// File: rtl/ibex_rf_write_arbiter.sv
// Write-port arbiter for the FPGA register file: clears all writable registers after reset or on request,
// then shares the single write port between the core writeback (fixed priority) and a secondary requester.
module ibex_rf_write_arbiter #(
  parameter bit                    RV32E        = 1'b0,
  parameter int unsigned           DataWidth    = 32,
  parameter logic [DataWidth-1:0]  WordZeroVal  = '0,
  parameter bit                    ClearOnReset = 1'b1,
  parameter int unsigned           StarveLimit  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  input  logic                 sec_valid_i,
  output logic                 sec_ready_o,
  input  logic [4:0]           sec_waddr_i,
  input  logic [DataWidth-1:0] sec_wdata_i,
  output logic                 wb_stall_o,
  output logic                 rf_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned      NumRegs  = RV32E ? 16 : 32;
  localparam logic [4:0]       LastAddr = 5'(NumRegs - 1);
  localparam int unsigned      CntW     = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(StarveLimit);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;
  localparam logic [0:0] StReset = ClearOnReset ? StClear : StRun;

  logic [0:0]           state_q, state_d;
  logic [4:0]           clr_addr_q, clr_addr_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 stall_q, stall_d;
  logic                 err_q, err_d;
  logic                 sec_ready_c;
  logic                 rf_we_c;
  logic [4:0]           rf_waddr_c;
  logic [DataWidth-1:0] rf_wdata_c;

  // State and bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StReset;
      clr_addr_q <= 5'd1;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic and zero-latency write-port selection
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    wait_cnt_d  = wait_cnt_q;
    stall_d     = stall_q;
    err_d       = 1'b0;
    sec_ready_c = 1'b0;
    rf_we_c     = 1'b0;
    rf_waddr_c  = wb_waddr_i;
    rf_wdata_c  = wb_wdata_i;

    case (state_q)
      StClear: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = clr_addr_q;
        rf_wdata_c = WordZeroVal;
        clr_addr_d = clr_addr_q + 5'd1;
        wait_cnt_d = '0;
        stall_d    = 1'b0;
        err_d      = wb_we_i;
        if (clr_addr_q == LastAddr) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (wb_we_i) begin
          rf_we_c = (wb_waddr_i != 5'd0);
          err_d   = stall_q;
        end else begin
          sec_ready_c = 1'b1;
          rf_waddr_c  = sec_waddr_i;
          rf_wdata_c  = sec_wdata_i;
          rf_we_c     = sec_valid_i && (sec_waddr_i != 5'd0);
        end

        // Starvation tracking: a stall stays up until the secondary actually transfers
        if (sec_valid_i && !sec_ready_c) begin
          if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
          if (wait_cnt_d == CntMax) begin
            stall_d = 1'b1;
          end
        end else if (sec_valid_i && sec_ready_c) begin
          wait_cnt_d = '0;
          stall_d    = 1'b0;
        end

        if (clear_req_i) begin
          state_d    = StClear;
          clr_addr_d = 5'd1;
          wait_cnt_d = '0;
          stall_d    = 1'b0;
        end
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

  // Handshake and write enable are forced low while reset is held
  assign sec_ready_o = sec_ready_c & ~rst_i;
  assign rf_we_o     = rf_we_c & ~rst_i;
  assign rf_waddr_o  = rf_waddr_c;
  assign rf_wdata_o  = rf_wdata_c;
  assign rf_ready_o  = (state_q == StRun);
  assign wb_stall_o  = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for ibex_rf_write_arbiter: a 32-register instance with clear-on-reset and
// a 16-register instance without it, sharing the write-request stimulus.
module tb_ibex_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req, e_clear_req;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        sec_valid;
  logic [4:0]  sec_waddr;
  logic [31:0] sec_wdata;

  logic        sec_ready, wb_stall, rf_ready, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        e_sec_ready, e_wb_stall, e_rf_ready, e_rf_we, e_err;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(
    .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'hDEADBEEF), .ClearOnReset(1'b1), .StarveLimit(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .sec_valid_i(sec_valid), .sec_ready_o(sec_ready), .sec_waddr_i(sec_waddr), .sec_wdata_i(sec_wdata),
    .wb_stall_o(wb_stall), .rf_ready_o(rf_ready), .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .err_o(err)
  );

  ibex_rf_write_arbiter #(
    .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0), .ClearOnReset(1'b0), .StarveLimit(4)
  ) dut_e (
    .clk_i(clk), .rst_i(rst), .clear_req_i(e_clear_req),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .sec_valid_i(sec_valid), .sec_ready_o(e_sec_ready), .sec_waddr_i(sec_waddr), .sec_wdata_i(sec_wdata),
    .wb_stall_o(e_wb_stall), .rf_ready_o(e_rf_ready), .rf_we_o(e_rf_we),
    .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .err_o(e_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; e_clear_req = 1'b0;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    sec_valid = 1'b0; sec_waddr = 5'd0; sec_wdata = 32'h0;

    // Reset values
    to_neg(); #1;
    chk("rst_rf_ready", 64'(rf_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_sec_ready", 64'(sec_ready), 64'd0);
    chk("rst_stall", 64'(wb_stall), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd1);
    chk("e_rst_rf_ready", 64'(e_rf_ready), 64'd1);
    chk("e_rst_sec_ready", 64'(e_sec_ready), 64'd0);
    to_neg();
    rst = 1'b0;

    // Power-on sweep x1..x31 with a stray core write and an ignored clear request
    for (int k = 1; k <= 31; k++) begin
      wb_we = (k == 3); wb_waddr = 5'd7; wb_wdata = 32'h77;
      clear_req = (k == 5);
      #1;
      chk($sformatf("sweep_we_%0d", k), 64'(rf_we), 64'd1);
      chk($sformatf("sweep_addr_%0d", k), 64'(rf_waddr), 64'(k));
      chk($sformatf("sweep_data_%0d", k), 64'(rf_wdata), 64'hDEADBEEF);
      chk($sformatf("sweep_sec_ready_%0d", k), 64'(sec_ready), 64'd0);
      chk($sformatf("sweep_ready_%0d", k), 64'(rf_ready), 64'd0);
      tick();
      chk($sformatf("sweep_err_%0d", k), 64'(err), 64'(k == 3));
      chk($sformatf("sweep_ready_post_%0d", k), 64'(rf_ready), 64'(k == 31));
      to_neg();
    end
    wb_we = 1'b0; clear_req = 1'b0;
    #1;
    chk("idle_rf_we", 64'(rf_we), 64'd0);
    chk("idle_sec_ready", 64'(sec_ready), 64'd1);
    to_neg();

    // Core priority, then the secondary wins once the core is idle
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h11;
    sec_valid = 1'b1; sec_waddr = 5'd6; sec_wdata = 32'h22;
    #1;
    chk("prio_we", 64'(rf_we), 64'd1);
    chk("prio_addr", 64'(rf_waddr), 64'd5);
    chk("prio_data", 64'(rf_wdata), 64'h11);
    chk("prio_sec_ready", 64'(sec_ready), 64'd0);
    to_neg();
    wb_we = 1'b0;
    #1;
    chk("sec_we", 64'(rf_we), 64'd1);
    chk("sec_addr", 64'(rf_waddr), 64'd6);
    chk("sec_data", 64'(rf_wdata), 64'h22);
    chk("sec_sec_ready", 64'(sec_ready), 64'd1);
    tick();
    chk("sec_stall", 64'(wb_stall), 64'd0);
    to_neg();

    // Starvation: stall rises at the 4th blocked edge, secondary accepted next cycle
    sec_waddr = 5'd12; sec_wdata = 32'h33;
    for (int j = 1; j <= 4; j++) begin
      wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'(j);
      #1;
      chk($sformatf("starve_sec_ready_%0d", j), 64'(sec_ready), 64'd0);
      chk($sformatf("starve_addr_%0d", j), 64'(rf_waddr), 64'd9);
      tick();
      chk($sformatf("starve_stall_%0d", j), 64'(wb_stall), 64'(j == 4));
      to_neg();
    end
    wb_we = 1'b0;
    #1;
    chk("starve_accept_ready", 64'(sec_ready), 64'd1);
    chk("starve_accept_addr", 64'(rf_waddr), 64'd12);
    chk("starve_accept_we", 64'(rf_we), 64'd1);
    tick();
    chk("starve_cleared", 64'(wb_stall), 64'd0);
    to_neg();

    // Core violates the stall: core wins, err pulses once, stall persists
    for (int j = 1; j <= 4; j++) begin
      wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'(j);
      tick();
      to_neg();
    end
    chk("viol_stall_up", 64'(wb_stall), 64'd1);
    wb_we = 1'b1; wb_waddr = 5'd10; wb_wdata = 32'h44;
    #1;
    chk("viol_addr", 64'(rf_waddr), 64'd10);
    chk("viol_data", 64'(rf_wdata), 64'h44);
    chk("viol_sec_ready", 64'(sec_ready), 64'd0);
    tick();
    chk("viol_err", 64'(err), 64'd1);
    chk("viol_stall_kept", 64'(wb_stall), 64'd1);
    to_neg();
    wb_we = 1'b0;
    #1;
    chk("viol_pending_ready", 64'(sec_ready), 64'd1);
    chk("viol_pending_addr", 64'(rf_waddr), 64'd12);
    tick();
    chk("viol_err_done", 64'(err), 64'd0);
    chk("viol_stall_done", 64'(wb_stall), 64'd0);
    to_neg();

    // Writes to x0 are suppressed from both sources
    sec_valid = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd0;
    #1;
    chk("x0_core_we", 64'(rf_we), 64'd0);
    to_neg();
    wb_we = 1'b0; sec_valid = 1'b1; sec_waddr = 5'd0;
    #1;
    chk("x0_sec_we", 64'(rf_we), 64'd0);
    chk("x0_sec_ready", 64'(sec_ready), 64'd1);
    to_neg();

    // RV32E clear request: request-cycle write completes, 15-cycle sweep, pending secondary after
    sec_waddr = 5'd6; sec_wdata = 32'h22; e_clear_req = 1'b1;
    #1;
    chk("e_req_ready", 64'(e_rf_ready), 64'd1);
    chk("e_req_sec_ready", 64'(e_sec_ready), 64'd1);
    chk("e_req_addr", 64'(e_rf_waddr), 64'd6);
    tick();
    chk("e_req_ready_post", 64'(e_rf_ready), 64'd0);
    to_neg();
    e_clear_req = 1'b0; sec_waddr = 5'd13; sec_wdata = 32'h55;
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk($sformatf("e_sweep_we_%0d", k), 64'(e_rf_we), 64'd1);
      chk($sformatf("e_sweep_addr_%0d", k), 64'(e_rf_waddr), 64'(k));
      chk($sformatf("e_sweep_data_%0d", k), 64'(e_rf_wdata), 64'h0);
      chk($sformatf("e_sweep_sec_ready_%0d", k), 64'(e_sec_ready), 64'd0);
      tick();
      chk($sformatf("e_sweep_ready_%0d", k), 64'(e_rf_ready), 64'(k == 15));
      to_neg();
    end
    #1;
    chk("e_run_sec_ready", 64'(e_sec_ready), 64'd1);
    chk("e_run_we", 64'(e_rf_we), 64'd1);
    chk("e_run_addr", 64'(e_rf_waddr), 64'd13);
    chk("e_run_data", 64'(e_rf_wdata), 64'h55);
    to_neg();

    // Reset mid-sweep aborts at once and the sweep restarts from x1
    rst = 1'b1;
    to_neg();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      to_neg();
    end
    #1;
    chk("abort_pre_addr", 64'(rf_waddr), 64'd10);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_rf_we", 64'(rf_we), 64'd0);
    chk("abort_sec_ready", 64'(sec_ready), 64'd0);
    chk("abort_rf_ready", 64'(rf_ready), 64'd0);
    chk("abort_stall", 64'(wb_stall), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_addr", 64'(rf_waddr), 64'd1);
    to_neg();
    rst = 1'b0;
    #1;
    chk("restart_we", 64'(rf_we), 64'd1);
    chk("restart_addr", 64'(rf_waddr), 64'd1);
    chk("restart_data", 64'(rf_wdata), 64'hDEADBEEF);
    tick();
    chk("restart_ready", 64'(rf_ready), 64'd0);
    to_neg();
    #1;
    chk("restart_addr2", 64'(rf_waddr), 64'd2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
